// File: rtl/vga_superpix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : vga_superpix_scanner
// Purpose  : 640x480 VGA raster generator with 32x32 superpixel indices
//            carried as incrementing counters. Option: VGA_SYNC_DELAY_EN
//            delays hsync/vsync/active one pixel to match 1-cycle tile memory.
// Revision : 1.0  initial release
// ============================================================================
module vga_superpix_scanner #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic [9:0] col,
   output logic [8:0] row,
   output logic [4:0] x_sup_pix,
   output logic [3:0] y_sup_pix,
   output logic [4:0] x_sub,
   output logic [4:0] y_sub,
   output logic       frame_start,
   output logic       line_end
);

   localparam logic [9:0] c_h_last = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] c_h_act  = 10'(H_ACTIVE);
   localparam logic [9:0] c_hs_beg = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_hs_end = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_v_last = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] c_v_act  = 10'(V_ACTIVE);
   localparam logic [9:0] c_vs_beg = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_vs_end = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_scan = 1'b1;

   logic [0:0] r_state;
   logic [0:0] w_state_nxt;

   logic [9:0] r_h_cnt, r_v_cnt;
   logic [4:0] r_x_sub, r_x_sup, r_y_sub;
   logic [3:0] r_y_sup;

   logic [9:0] w_h_nxt, w_v_nxt;
   logic [4:0] w_xs_nxt, w_xp_nxt, w_ys_nxt;
   logic [3:0] w_yp_nxt;
   logic       w_line_wrap;
   logic       w_act;
   logic       w_hs_nxt, w_vs_nxt;

   logic       r_hsync_s, r_vsync_s, r_active_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_st_idle;
      else     r_state <= w_state_nxt;
   end

   // Next state: the first enabled pixel after reset loads (0,0) instead of advancing
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (pix_en) w_state_nxt = c_st_scan;
         c_st_scan: w_state_nxt = c_st_scan;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   // Next-position datapath
   always_comb begin
      w_line_wrap = (r_state == c_st_scan) && (r_h_cnt == c_h_last);
      w_h_nxt  = '0;
      w_v_nxt  = '0;
      w_xs_nxt = '0;
      w_xp_nxt = '0;
      w_ys_nxt = '0;
      w_yp_nxt = '0;
      if (r_state == c_st_scan) begin
         w_h_nxt = w_line_wrap ? 10'd0 : r_h_cnt + 10'd1;
         w_v_nxt = r_v_cnt;
         if (w_line_wrap)
            w_v_nxt = (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;

         w_xs_nxt = r_x_sub;
         w_xp_nxt = r_x_sup;
         if (w_h_nxt == 10'd0) begin
            w_xs_nxt = '0;
            w_xp_nxt = '0;
         end else if (w_h_nxt < c_h_act) begin
            if (r_x_sub == 5'd31) begin
               w_xs_nxt = '0;
               w_xp_nxt = r_x_sup + 5'd1;
            end else begin
               w_xs_nxt = r_x_sub + 5'd1;
            end
         end

         w_ys_nxt = r_y_sub;
         w_yp_nxt = r_y_sup;
         if (w_line_wrap) begin
            if (w_v_nxt == 10'd0) begin
               w_ys_nxt = '0;
               w_yp_nxt = '0;
            end else if (w_v_nxt < c_v_act) begin
               if (r_y_sub == 5'd31) begin
                  w_ys_nxt = '0;
                  w_yp_nxt = r_y_sup + 4'd1;
               end else begin
                  w_ys_nxt = r_y_sub + 5'd1;
               end
            end
         end
      end
      w_act    = (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);
      w_hs_nxt = !((w_h_nxt >= c_hs_beg) && (w_h_nxt <= c_hs_end));
      w_vs_nxt = !((w_v_nxt >= c_vs_beg) && (w_v_nxt <= c_vs_end));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_x_sub     <= '0;
         r_x_sup     <= '0;
         r_y_sub     <= '0;
         r_y_sup     <= '0;
         r_hsync_s   <= 1'b1;
         r_vsync_s   <= 1'b1;
         r_active_s  <= 1'b0;
         col         <= '0;
         row         <= '0;
         x_sup_pix   <= '0;
         y_sup_pix   <= '0;
         x_sub       <= '0;
         y_sub       <= '0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         line_end    <= 1'b0;
         if (pix_en) begin
            r_h_cnt     <= w_h_nxt;
            r_v_cnt     <= w_v_nxt;
            r_x_sub     <= w_xs_nxt;
            r_x_sup     <= w_xp_nxt;
            r_y_sub     <= w_ys_nxt;
            r_y_sup     <= w_yp_nxt;
            r_hsync_s   <= w_hs_nxt;
            r_vsync_s   <= w_vs_nxt;
            r_active_s  <= w_act;
            col         <= w_act ? w_h_nxt      : 10'd0;
            row         <= w_act ? w_v_nxt[8:0] : 9'd0;
            x_sup_pix   <= w_act ? w_xp_nxt     : 5'd0;
            y_sup_pix   <= w_act ? w_yp_nxt     : 4'd0;
            x_sub       <= w_act ? w_xs_nxt     : 5'd0;
            y_sub       <= w_act ? w_ys_nxt     : 5'd0;
            frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
            line_end    <= (w_h_nxt == c_h_last);
         end
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   // Extra pixel of lag on sync/active so they line up with tile-memory read data
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync  <= 1'b1;
         vsync  <= 1'b1;
         active <= 1'b0;
      end else if (pix_en) begin
         hsync  <= r_hsync_s;
         vsync  <= r_vsync_s;
         active <= r_active_s;
      end
   end
`else
   assign hsync  = r_hsync_s;
   assign vsync  = r_vsync_s;
   assign active = r_active_s;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_superpix_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_superpix_scanner
// Purpose  : Scoreboard bench: full-size instance for line behaviour, reduced
//            instance for whole-frame behaviour. Honours VGA_SYNC_DELAY_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_superpix_scanner;

   logic clk = 1'b0;
   logic rst;
   logic pix_en;
   always #5 clk = ~clk;

   logic       hs0, vs0, ac0, fs0, le0;
   logic [9:0] col0;
   logic [8:0] row0;
   logic [4:0] xp0, xs0, ys0;
   logic [3:0] yp0;
   logic       hs1, vs1, ac1, fs1, le1;
   logic [9:0] col1;
   logic [8:0] row1;
   logic [4:0] xp1, xs1, ys1;
   logic [3:0] yp1;

   vga_superpix_scanner dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hs0), .vsync(vs0), .active(ac0), .col(col0), .row(row0),
      .x_sup_pix(xp0), .y_sup_pix(yp0), .x_sub(xs0), .y_sub(ys0),
      .frame_start(fs0), .line_end(le0)
   );

   vga_superpix_scanner #(
      .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(70), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_s (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hs1), .vsync(vs1), .active(ac1), .col(col1), .row(row1),
      .x_sup_pix(xp1), .y_sup_pix(yp1), .x_sub(xs1), .y_sub(ys1),
      .frame_start(fs1), .line_end(le1)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected output vector from a raster position, computed directly
   function automatic logic [42:0] exp_of(input int h, input int v, input int ha, input int hfp,
                                          input int hsw, input int htot, input int va,
                                          input int vfp, input int vsw);
      logic       act, hs, vs, fs, le;
      logic [9:0] c;
      logic [8:0] r;
      act = (h < ha) && (v < va);
      c   = act ? 10'(h) : 10'd0;
      r   = act ? 9'(v)  : 9'd0;
      hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
      vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
      fs  = (h == 0) && (v == 0);
      le  = (h == htot - 1);
      return {hs, vs, act, c, r, c[9:5], r[8:5], c[4:0], r[4:0], fs, le};
   endfunction

   int          ha[2]   = '{640, 80};
   int          hfp[2]  = '{16, 4};
   int          hsw[2]  = '{96, 8};
   int          htot[2] = '{800, 96};
   int          va[2]   = '{480, 70};
   int          vfp[2]  = '{10, 2};
   int          vsw[2]  = '{2, 2};
   int          vtot[2] = '{525, 77};
   int          m_h[2], m_v[2];
   bit          m_st[2];
   logic [42:0] m_last[2];
   logic [2:0]  m_s1[2];
   logic [42:0] q0[$];
   logic [42:0] q1[$];
   bit          en_seen;

   // Reference model: one expected vector pushed per clock for each instance
   always @(posedge clk) begin
      logic [42:0] e;
      logic [2:0]  t;
      en_seen = pix_en && !rst;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_st[i] = 1'b0;
            m_h[i]  = 0;
            m_v[i]  = 0;
            m_s1[i] = 3'b110;
            e       = {2'b11, 41'd0};
         end else if (pix_en) begin
            if (!m_st[i]) begin
               m_st[i] = 1'b1;
               m_h[i]  = 0;
               m_v[i]  = 0;
            end else if (m_h[i] == htot[i] - 1) begin
               m_h[i] = 0;
               m_v[i] = (m_v[i] == vtot[i] - 1) ? 0 : m_v[i] + 1;
            end else begin
               m_h[i] = m_h[i] + 1;
            end
            e = exp_of(m_h[i], m_v[i], ha[i], hfp[i], hsw[i], htot[i], va[i], vfp[i], vsw[i]);
`ifdef VGA_SYNC_DELAY_EN
            t         = e[42:40];
            e[42:40]  = m_s1[i];
            m_s1[i]   = t;
`endif
         end else begin
            e      = m_last[i];
            e[1:0] = 2'b00;
         end
         m_last[i] = e;
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   end

   int hcnt = 0, fcnt = 0, vlines = 0;
   bit hvalid = 0, fvalid = 0;

   // Compare DUT outputs against the scoreboard away from the active edge
   always @(negedge clk) begin
      logic [42:0] g0, g1;
      g0 = {hs0, vs0, ac0, col0, row0, xp0, yp0, xs0, ys0, fs0, le0};
      g1 = {hs1, vs1, ac1, col1, row1, xp1, yp1, xs1, ys1, fs1, le1};
      if (q0.size() > 0) check("full_vec", 64'(g0), 64'(q0.pop_front()));
      if (q1.size() > 0) check("small_vec", 64'(g1), 64'(q1.pop_front()));
      if (rst) begin
         hvalid = 0; hcnt = 0;
         fvalid = 0; fcnt = 0; vlines = 0;
      end else if (en_seen) begin
         if (!hs0) hcnt++;
         if (le0) begin
            if (hvalid) check("hsync_width", 64'(hcnt), 64'd96);
            hvalid = 1;
            hcnt   = 0;
         end
         if (fs1) begin
            if (fvalid) begin
               check("frame_len", 64'(fcnt), 64'd7392);
               check("vsync_lines", 64'(vlines), 64'd2);
            end
            fvalid = 1;
            fcnt   = 1;
            vlines = 0;
         end else begin
            fcnt++;
         end
         if (le1 && !vs1) vlines++;
      end
   end

   initial begin
      rst    = 1'b1;
      pix_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3400; i++) begin
         pix_en = (i % 2 == 0);
         @(negedge clk);
      end
      pix_en = 1'b0;
      repeat (10) @(negedge clk);
      pix_en = 1'b1;
      repeat (8000) @(negedge clk);
      begin
         int k;
         for (k = 0; k < 1000 && m_h[0] != 299; k++) @(negedge clk);
         if (k >= 1000) check("wait_col299", 64'd0, 64'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pix_en = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         pix_en = (i % 2 == 0);
         @(negedge clk);
      end
      rst = 1'b1;
      pix_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_superpix_scanner.md
Name: vga_superpix_scanner

Overview:
- Raster scan generator for the 640x480 VGA path.
- Produces hsync, vsync and an active-video flag.
- Also outputs pixel col/row plus the matching 32x32 superpixel index (20x15 grid) and the sub-pixel offset within that superpixel.
- Superpixel/sub counters are carried as their own incrementing counters, with no divide or compare chains, so tile-map logic downstream gets indices directly from the scan.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-rate enable (e.g. 1-in-2 at 50 MHz clk); all state advances only when high
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  high when the current position is inside 640x480
- col  out  10  active-area column 0..639; 0 during blanking
- row  out  9  active-area row 0..479; 0 during blanking
- x_sup_pix  out  5  superpixel column 0..19; 0 during blanking
- y_sup_pix  out  4  superpixel row 0..14; 0 during blanking
- x_sub  out  5  column within superpixel 0..31; 0 during blanking
- y_sub  out  5  row within superpixel 0..31; 0 during blanking
- frame_start  out  1  one-clk pulse when position (0,0) is loaded
- line_end  out  1  one-clk pulse when h = H_TOTAL-1 is loaded

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - h_cnt = 0, v_cnt = 0
  - hsync = 1, vsync = 1, active = 0
  - col, row, x_sup_pix, y_sup_pix, x_sub, y_sub = 0
  - frame_start = 0, line_end = 0
  - Internal "started" flag cleared.
- Latency: outputs show the position loaded on the most recent pix_en.
  - First pix_en after reset loads (h=0, v=0): active = 1, frame_start = 1.
  - Nth pix_en after reset shows position N-1 in raster order.
- Horizontal counter h_cnt, 0..799: increments on pix_en and wraps 799 -> 0. On wrap, v_cnt increments.
- Vertical counter v_cnt, 0..524: wraps 524 -> 0 on the line wrap.
- active = (h < 640) && (v < 480).
- hsync = 0 for h in 656..751; otherwise 1.
- vsync = 0 for v in 490..491; otherwise 1.
- x_sub increments with col; at 31 it wraps to 0 and x_sup_pix increments.
  - Both clear at h = 0 of each line.
  - Both are forced to 0 outside the active area.
- y_sub / y_sup_pix follow the same rule per line, advancing at each line wrap while v < 480. Both clear at frame wrap.
- Invariant (active only): x_sup_pix = col[9:5], x_sub = col[4:0], y_sup_pix = row[8:5], y_sub = row[4:0]. No out-of-range or X values are ever driven.
- pix_en low: every output, including the sync signals, holds. frame_start and line_end are 0 on any clk where pix_en is low; each pulse lasts exactly one clk.
- rst while pix_en is high: rst wins. The counters do not advance that cycle.
- rst mid-frame: immediate return to reset values on that clk. The scan restarts at (0,0) on the next pix_en.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined: hsync, vsync and active pass through one extra pix_en-qualified register stage. They lag col/row/superpixel outputs by one pixel, aligning with a tile memory that has 1-cycle read latency. The extra stage resets to hsync = 1, vsync = 1, active = 0.
- Undefined: all outputs are aligned to the same position.

Test Plan:
- Reset, then pix_en toggling 1-in-2 -> after first pix_en: col=0, row=0, active=1, frame_start pulses 1 clk; hsync=1, vsync=1.
- Step to col 31 -> 32 -> x_sup_pix goes 0 -> 1 and x_sub 31 -> 0. At col 639: x_sup_pix=19, x_sub=31. At h=640: active=0 and all index outputs = 0.
- Horizontal sweep -> hsync low exactly for h 656..751 (96 pixels). line_end at h=799; next position is h=0 with row incremented.
- Full frame -> vsync low for lines 490..491 only. At row 479: y_sup_pix=14, y_sub=31. After v=524 h=799, the next position is (0,0) with frame_start. Exactly 420000 pix_en per frame.
- Hold pix_en low 10 clks mid-line -> all outputs stable, no pulses.
- Assert rst at row 200, col 300 -> next clk shows reset values. With VGA_SYNC_DELAY_EN, sync/active lag col by one pix_en.
